imem_loader: RTL and testbench

- Writer side of the instruction-memory port that the fetch stage reads.
- Receives a byte stream with a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory through its write port (wea/addra/dina).
- Holds the core in reset until the program load completes, then releases it.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_BASE_ADDR  = 0;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd3
  } state_e;

  function automatic logic is_last_lane(input logic [1:0] idx);
    return idx == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word lane register; o_word_ready flags the byte
// completing a word, and o_word already contains that byte.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [23:0] r_lanes;
  logic [1:0]  r_idx;

  assign o_word_ready = i_byte_en && is_last_lane(r_idx);
  assign o_word       = {i_byte, r_lanes};

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_lanes <= 24'd0;
      r_idx   <= 2'd0;
    end else if (o_word_ready) begin
      r_lanes <= 24'd0;
      r_idx   <= 2'd0;
    end else if (i_byte_en) begin
      r_lanes[8*r_idx +: 8] <= i_byte;
      r_idx                 <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core
// until done. IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum and chk_err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk1,
  input  logic              rst,
  imem_loader_if.slave      byte_if,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
`ifdef IMEM_LOADER_CHKSUM_EN
  , output logic            chk_err
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e              r_state, w_state_nxt, w_state_last;
  logic                r_in_ready, r_mem_we, r_core_hold, r_done;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [ADDR_W:0]     r_word_cnt;
  logic [7:0]          r_remaining;
  logic                w_xfer, w_reload, w_byte_en, w_word_ready;
  logic [31:0]         w_word;
  logic                w_in_ready_nxt, w_mem_we_nxt, w_done_nxt, w_core_hold_nxt;
  logic                w_chk_err_nxt;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]          r_chk;
  logic                r_chk_err;
`endif

  assign w_xfer    = byte_if.in_valid && r_in_ready;
  assign w_reload  = (r_state == ST_DONE) && load_req;
  assign w_byte_en = w_xfer && (r_state == ST_DATA);

  imem_loader_word_assembler u_asm (
    .i_clk        (clk1),
    .i_rst        (rst),
    .i_clr        (w_reload),
    .i_byte_en    (w_byte_en),
    .i_byte       (byte_if.in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

`ifdef IMEM_LOADER_CHKSUM_EN
  assign w_state_last = ST_CHK;
`else
  assign w_state_last = ST_DONE;
`endif

  always_ff @(posedge clk1) begin
    if (!rst) r_state <= ST_LEN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LEN:   if (w_xfer) w_state_nxt = (byte_if.in_data == 8'd0) ? ST_DONE : ST_DATA;
                else        w_state_nxt = r_state;
      ST_DATA:  if (w_word_ready) w_state_nxt = ST_WRITE;
                else              w_state_nxt = r_state;
      ST_WRITE: if (r_remaining == 8'd1) w_state_nxt = w_state_last;
                else                     w_state_nxt = ST_DATA;
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHK:   if (w_xfer) w_state_nxt = ST_DONE;
                else        w_state_nxt = r_state;
`endif
      ST_DONE:  if (load_req) w_state_nxt = ST_LEN;
                else          w_state_nxt = r_state;
      default:  w_state_nxt = ST_LEN;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_in_ready_nxt = (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA);
`ifdef IMEM_LOADER_CHKSUM_EN
    w_in_ready_nxt = w_in_ready_nxt || (w_state_nxt == ST_CHK);
    w_chk_err_nxt  = r_chk_err;
    if (w_reload)                               w_chk_err_nxt = 1'b0;
    else if ((r_state == ST_CHK) && w_xfer)     w_chk_err_nxt = (byte_if.in_data != r_chk);
    else                                        w_chk_err_nxt = r_chk_err;
`else
    w_chk_err_nxt  = 1'b0;
`endif
    w_mem_we_nxt    = (w_state_nxt == ST_WRITE);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_core_hold_nxt = !w_done_nxt || w_chk_err_nxt;
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_core_hold <= 1'b1;
      r_mem_addr  <= BASE;
      r_mem_wdata <= '0;
      r_word_cnt  <= '0;
      r_remaining <= 8'd0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_done      <= w_done_nxt;
      r_core_hold <= w_core_hold_nxt;
      if (w_reload) begin
        r_mem_addr <= BASE;
        r_word_cnt <= '0;
      end else if (r_state == ST_WRITE) begin
        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
        r_word_cnt  <= r_word_cnt + (ADDR_W+1)'(1);
        r_remaining <= r_remaining - 8'd1;
      end
      if ((r_state == ST_LEN) && w_xfer) r_remaining <= byte_if.in_data;
      if (w_word_ready) r_mem_wdata <= DATA_W'(w_word);
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  // Running XOR covers the length byte and every data byte.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_chk     <= 8'd0;
      r_chk_err <= 1'b0;
    end else begin
      r_chk_err <= w_chk_err_nxt;
      if ((r_state == ST_LEN) && w_xfer)  r_chk <= byte_if.in_data;
      else if (w_byte_en)                 r_chk <= r_chk ^ byte_if.in_data;
    end
  end
  assign chk_err = r_chk_err;
`endif

  assign byte_if.in_ready = r_in_ready;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign core_hold        = r_core_hold;
  assign done             = r_done;
  assign word_cnt         = r_word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 254) share one stream.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk1 = 1'b0;
  logic        rst, load_req, tb_valid;
  logic [7:0]  tb_data;
  logic        mem_we_a, mem_we_b, core_hold_a, core_hold_b, done_a, done_b;
  logic [7:0]  mem_addr_a, mem_addr_b;
  logic [31:0] mem_wdata_a, mem_wdata_b;
  logic [8:0]  word_cnt_a, word_cnt_b;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic        chk_err_a, chk_err_b;
`endif

  always #5 clk1 = ~clk1;

  imem_loader_if bus_a();
  imem_loader_if bus_b();
  assign bus_a.in_valid = tb_valid;
  assign bus_a.in_data  = tb_data;
  assign bus_b.in_valid = tb_valid;
  assign bus_b.in_data  = tb_data;

  imem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0)) u_dut (
    .clk1(clk1), .rst(rst), .byte_if(bus_a), .load_req(load_req),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .core_hold(core_hold_a), .done(done_a), .word_cnt(word_cnt_a)
`ifdef IMEM_LOADER_CHKSUM_EN
    , .chk_err(chk_err_a)
`endif
  );

  imem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(254)) u_dut_b (
    .clk1(clk1), .rst(rst), .byte_if(bus_b), .load_req(load_req),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .core_hold(core_hold_b), .done(done_b), .word_cnt(word_cnt_b)
`ifdef IMEM_LOADER_CHKSUM_EN
    , .chk_err(chk_err_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] wr_a[$];
  logic [39:0] wr_b[$];
  int we_cyc_a = 0;
  int rdy_viol = 0;
  logic [7:0] run_xor;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk1) begin
    if (mem_we_a === 1'b1) begin
      wr_a.push_back({mem_addr_a, mem_wdata_a});
      we_cyc_a++;
      if (bus_a.in_ready !== 1'b0) rdy_viol++;
    end
    if (mem_we_b === 1'b1) wr_b.push_back({mem_addr_b, mem_wdata_b});
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent = 1'b0;
    repeat (gap) begin
      tb_valid = 1'b0;
      @(posedge clk1); #1;
    end
    tb_valid = 1'b1;
    tb_data  = b;
    for (int t = 0; t < 50 && !sent; t++) begin
      if (bus_a.in_ready === 1'b1) sent = 1'b1;
      @(posedge clk1); #1;
    end
    tb_valid = 1'b0;
    if (sent) run_xor = run_xor ^ b;
    else      check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_stream(input logic [7:0] n);
    run_xor = 8'd0;
    send_byte(n, 0);
  endtask

  task automatic end_stream();
`ifdef IMEM_LOADER_CHKSUM_EN
    send_byte(run_xor, 0);
`endif
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk1); #1;
    load_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_b.delete();
    we_cyc_a = 0;
    rdy_viol = 0;
  endtask

  logic [7:0] t1_bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] t4_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load_req = 1'b0; tb_valid = 1'b0; tb_data = 8'd0; run_xor = 8'd0;
    idle(2);
    check_val("rst_in_ready",  32'(bus_a.in_ready), 32'd1);
    check_val("rst_mem_we",    32'(mem_we_a),       32'd0);
    check_val("rst_addr",      32'(mem_addr_a),     32'd0);
    check_val("rst_addr_b",    32'(mem_addr_b),     32'hFE);
    check_val("rst_wdata",     mem_wdata_a,         32'd0);
    check_val("rst_core_hold", 32'(core_hold_a),    32'd1);
    check_val("rst_done",      32'(done_a),         32'd0);
    check_val("rst_word_cnt",  32'(word_cnt_a),     32'd0);
    rst = 1'b1;
    idle(1);

    // N=2 back-to-back
    clear_mon();
    start_stream(8'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(t1_bytes[i], 0);
      if (i == 3) check_val("t1_latency_we", 32'(mem_we_a), 32'd1);
    end
    end_stream();
    idle(3);
    check_val("t1_nwrites",   32'(wr_a.size()),   32'd2);
    check_val("t1_w0_addr",   32'(wr_a[0][39:32]), 32'h00);
    check_val("t1_w0_data",   wr_a[0][31:0],       32'h12345678);
    check_val("t1_w1_addr",   32'(wr_a[1][39:32]), 32'h01);
    check_val("t1_w1_data",   wr_a[1][31:0],       32'hDEADBEEF);
    check_val("t1_we_cycles", 32'(we_cyc_a),       32'd2);
    check_val("t1_done",      32'(done_a),         32'd1);
    check_val("t1_core_hold", 32'(core_hold_a),    32'd0);
    check_val("t1_word_cnt",  32'(word_cnt_a),     32'd2);
    check_val("t1_done_ready", 32'(bus_a.in_ready), 32'd0);

    pulse_load();
    check_val("rl_core_hold", 32'(core_hold_a), 32'd1);
    check_val("rl_done",      32'(done_a),      32'd0);
    check_val("rl_word_cnt",  32'(word_cnt_a),  32'd0);
    check_val("rl_addr",      32'(mem_addr_a),  32'd0);

    // N=0: done the cycle after the length byte
    clear_mon();
    start_stream(8'd0);
    check_val("t2_done",      32'(done_a),      32'd1);
    check_val("t2_core_hold", 32'(core_hold_a), 32'd0);
    idle(3);
    check_val("t2_word_cnt",  32'(word_cnt_a),  32'd0);
    check_val("t2_no_we",     32'(we_cyc_a),    32'd0);

    // N=3 with random gaps; instance b wraps FE, FF, 00
    pulse_load();
    clear_mon();
    start_stream(8'd3);
    for (int i = 0; i < 12; i++) send_byte(8'(i), int'($urandom_range(0, 3)));
    end_stream();
    idle(3);
    check_val("t3_nwrites", 32'(wr_a.size()),    32'd3);
    check_val("t3_w0",      wr_a[0][31:0],       32'h03020100);
    check_val("t3_w1",      wr_a[1][31:0],       32'h07060504);
    check_val("t3_w2",      wr_a[2][31:0],       32'h0B0A0908);
    check_val("t3_a2",      32'(wr_a[2][39:32]), 32'h02);
    check_val("t3_b_a0",    32'(wr_b[0][39:32]), 32'hFE);
    check_val("t3_b_a1",    32'(wr_b[1][39:32]), 32'hFF);
    check_val("t3_b_a2",    32'(wr_b[2][39:32]), 32'h00);
    check_val("t3_b_w2",    wr_b[2][31:0],       32'h0B0A0908);
    check_val("t3_rdy_in_write", 32'(rdy_viol),  32'd0);
    check_val("t3_word_cnt", 32'(word_cnt_a),    32'd3);

    // Reset mid-load, then a fresh N=1 stream
    pulse_load();
    start_stream(8'd4);
    for (int i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i), 0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    clear_mon();
    check_val("t4_rst_word_cnt", 32'(word_cnt_a), 32'd0);
    check_val("t4_rst_addr",     32'(mem_addr_a), 32'd0);
    start_stream(8'd1);
    for (int i = 0; i < 4; i++) send_byte(t4_bytes[i], 0);
    end_stream();
    idle(3);
    check_val("t4_nwrites", 32'(wr_a.size()),    32'd1);
    check_val("t4_data",    wr_a[0][31:0],       32'hDDCCBBAA);
    check_val("t4_addr",    32'(wr_a[0][39:32]), 32'h00);
    check_val("t4_b_addr",  32'(wr_b[0][39:32]), 32'hFE);
    check_val("t4_done",    32'(done_a),         32'd1);

`ifdef IMEM_LOADER_CHKSUM_EN
    pulse_load();
    start_stream(8'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    idle(2);
    check_val("c1_chk_err",   32'(chk_err_a),   32'd0);
    check_val("c1_core_hold", 32'(core_hold_a), 32'd0);
    check_val("c1_done",      32'(done_a),      32'd1);
    pulse_load();
    start_stream(8'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h00, 0);
    idle(2);
    check_val("c2_chk_err",   32'(chk_err_a),   32'd1);
    check_val("c2_core_hold", 32'(core_hold_a), 32'd1);
    check_val("c2_done",      32'(done_a),      32'd1);
    pulse_load();
    check_val("c3_chk_err",   32'(chk_err_a),   32'd0);
    check_val("c3_done",      32'(done_a),      32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
